// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings and datapath widths.
package data_mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// dmem_wait_counter: 4-bit loadable down-counter; tc flags the last wait cycle (count == 1).
module dmem_wait_counter
    import data_mem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a load/store port with wait states and a one-cycle ready pulse.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns addr[1:0] != 0 into an error access.
//
// state     | meaning
// DMEM_IDLE | waiting for memread/memwrite; inputs used live on the accept edge
// DMEM_WAIT | counting wait states on latched addr/wdata/op
// DMEM_DONE | ready (and error) high for this single cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] readdata,
    output logic              ready,
    output logic              error
);

    localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    dmem_state_t state, next_state;

    logic [WORD_W-1:0] addr_q, wdata_q;
    logic              write_q;

    logic              accept, commit;
    logic              cnt_load, cnt_dec, cnt_tc;
    logic [WORD_W-1:0] acc_addr, acc_wdata, word_idx;
    logic              acc_write, out_of_range, misaligned, bad_access;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    dmem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (WAIT_LOAD),
        .tc         (cnt_tc)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (memread || memwrite) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        next_state = DMEM_DONE;
                    end else begin
                        next_state = DMEM_WAIT;
                        cnt_load   = 1'b1;
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_tc) next_state = DMEM_DONE;
            end
            DMEM_DONE: next_state = DMEM_IDLE;
            default:   next_state = DMEM_IDLE;
        endcase
    end

    // With zero wait states the access completes on the accept edge, so IDLE uses the live inputs.
    always_comb begin
        if (state == DMEM_IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_write = memwrite;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = write_q;
        end
    end

    assign commit       = (next_state == DMEM_DONE) && (state != DMEM_DONE);
    assign word_idx     = (acc_addr - BASE_ADDR) >> 2;
    assign out_of_range = (word_idx >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (acc_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign bad_access = out_of_range || misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DMEM_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            readdata <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= next_state;
            ready <= commit;
            error <= commit && bad_access;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                write_q <= memwrite;
            end
            if (commit) begin
                if (bad_access) begin
                    readdata <= '0;
                end else if (!acc_write) begin
                    readdata <= mem[word_idx[IDX_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && acc_write && !bad_access) begin
            mem[word_idx[IDX_W-1:0]] <= acc_wdata;
        end
    end

endmodule
